// File: rtl/upsample_pkg.sv
// Shared CNN datapath definitions: map sizes, pixel width and layer FSM state types.
// Used by the upsample block; UPSAMPLE_ZERO_FILL_EN is consumed in rtl/upsample.sv.
package upsample_pkg;

   localparam int DATA_WIDTH       = 16;
   localparam int CONV_OFMAP_SIZE  = 5;
   localparam int POOL_OFMAP_SIZE  = (CONV_OFMAP_SIZE + 1) / 2;
   localparam int POOL_PIXEL_COUNT = POOL_OFMAP_SIZE * POOL_OFMAP_SIZE;

   typedef enum logic [1:0] {
      POOL_IDLE       = 2'd0,
      POOL_PROCESSING = 2'd1,
      POOL_DONE       = 2'd2
   } pool_state_t;

   typedef enum logic [1:0] {
      UP_IDLE       = 2'd0,
      UP_PROCESSING = 2'd1,
      UP_DRAIN      = 2'd2,
      UP_DONE       = 2'd3
   } up_state_t;

   // A 1x1 map still needs a 1-bit index so the counters never collapse to zero width.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/upsample_addr_gen.sv
// Row-major scan of the pooled input map: row/col counters with wrap and a pixel count
// whose terminal value flags that every input pixel has been issued.
module upsample_addr_gen
   import upsample_pkg::*;
#(
   parameter int SIZE = 2,
   parameter int AW   = idx_width(SIZE),
   parameter int CW   = $clog2(SIZE * SIZE) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear_i,
   input  logic          step_i,
   output logic [AW-1:0] row_o,
   output logic [AW-1:0] col_o,
   output logic          last_o
);

   localparam logic [CW-1:0] CNT_LAST = CW'(SIZE * SIZE);
   localparam logic [AW-1:0] IDX_LAST = AW'(SIZE - 1);

   logic [AW-1:0] row_q, row_d;
   logic [AW-1:0] col_q, col_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         row_d = '0;
         col_d = '0;
         cnt_d = '0;
      end else if (step_i && (cnt_q < CNT_LAST)) begin
         cnt_d = cnt_q + 1'b1;
         if (col_q == IDX_LAST) begin
            col_d = '0;
            row_d = (row_q == IDX_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_q <= '0;
         col_q <= '0;
         cnt_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
         cnt_q <= cnt_d;
      end
   end

   assign row_o  = row_q;
   assign col_o  = col_q;
   assign last_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/upsample.sv
// Nearest-neighbour 2x upsampler: each pooled pixel is written into its 2x2 output window.
// Define UPSAMPLE_ZERO_FILL_EN for max-unpool style (pixel only at the window's top-left).
//
// state         | meaning
// UP_IDLE       | counters cleared, waiting for en
// UP_PROCESSING | scanning input pixels through the two-stage pipeline
// UP_DRAIN      | one cycle after the last write
// UP_DONE       | up_done high, held until en drops
module upsample
#(
   parameter int DATA_WIDTH      = upsample_pkg::DATA_WIDTH,
   parameter int CONV_OFMAP_SIZE = upsample_pkg::CONV_OFMAP_SIZE,
   parameter int POOL_OFMAP_SIZE = (CONV_OFMAP_SIZE + 1) / 2
) (
   input  logic                                                        clk,
   input  logic                                                        reset,
   input  logic                                                        en,
   input  logic [POOL_OFMAP_SIZE-1:0][POOL_OFMAP_SIZE-1:0][DATA_WIDTH-1:0] up_ifmap,
   output logic [CONV_OFMAP_SIZE-1:0][CONV_OFMAP_SIZE-1:0][DATA_WIDTH-1:0] up_ofmap,
   output logic                                                        up_done
);
   import upsample_pkg::*;

   localparam int AW = idx_width(POOL_OFMAP_SIZE);
   localparam int CW = $clog2(POOL_OFMAP_SIZE * POOL_OFMAP_SIZE) + 1;

   up_state_t state_q, state_d;

   logic [AW-1:0]         scan_row, scan_col;
   logic                  scan_last;
   logic                  capture;
   logic [DATA_WIDTH-1:0] pix_q;
   logic [AW-1:0]         pipe_row_q, pipe_col_q;
   logic                  pipe_valid_q;
   logic                  done_q;
   int                    r_base, c_base;

   upsample_addr_gen #(
      .SIZE (POOL_OFMAP_SIZE),
      .AW   (AW),
      .CW   (CW)
   ) u_addr_gen (
      .clk     (clk),
      .reset   (reset),
      .clear_i (state_q != UP_PROCESSING),
      .step_i  (state_q == UP_PROCESSING),
      .row_o   (scan_row),
      .col_o   (scan_col),
      .last_o  (scan_last)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         UP_IDLE:       if (en) state_d = UP_PROCESSING;
         UP_PROCESSING: begin
            if (scan_last)  state_d = UP_DRAIN;
            else if (!en)   state_d = UP_IDLE;
         end
         UP_DRAIN:      state_d = UP_DONE;
         UP_DONE:       if (!en) state_d = UP_IDLE;
         default:       state_d = UP_IDLE;
      endcase
   end

   // An aborting cycle (en low) must not capture, so the valid bit clears on the way out.
   assign capture = (state_q == UP_PROCESSING) && !scan_last && en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= UP_IDLE;
         pix_q        <= '0;
         pipe_row_q   <= '0;
         pipe_col_q   <= '0;
         pipe_valid_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pipe_valid_q <= capture;
         done_q       <= (state_d == UP_DONE);
         if (capture) begin
            pix_q      <= up_ifmap[scan_row][scan_col];
            pipe_row_q <= scan_row;
            pipe_col_q <= scan_col;
         end
      end
   end

   always_comb begin
      r_base = 2 * int'(pipe_row_q);
      c_base = 2 * int'(pipe_col_q);
   end

   // Window positions beyond the output edge have no element here, so odd sizes clip naturally.
   for (genvar gr = 0; gr < CONV_OFMAP_SIZE; gr++) begin : g_row
      for (genvar gc = 0; gc < CONV_OFMAP_SIZE; gc++) begin : g_col
         logic [DATA_WIDTH-1:0] px_q;
         logic                  hit;

         assign hit = pipe_valid_q
                    && ((gr == r_base) || (gr == r_base + 1))
                    && ((gc == c_base) || (gc == c_base + 1));

`ifdef UPSAMPLE_ZERO_FILL_EN
         logic anchor;
         assign anchor = (gr == r_base) && (gc == c_base);
`endif

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               px_q <= '0;
            end else if (hit) begin
`ifdef UPSAMPLE_ZERO_FILL_EN
               px_q <= anchor ? pix_q : '0;
`else
               px_q <= pix_q;
`endif
            end
         end

         assign up_ofmap[gr][gc] = px_q;
      end
   end

   assign up_done = done_q;

endmodule

// File: tb/tb_upsample.sv
// Self-checking bench for upsample: a 4x4 (pool 2x2) and a 5x5 (pool 3x3) instance
// checked against a behavioural model of the window expansion.
module tb_upsample;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic                    en4, en5;
   logic [1:0][1:0][15:0]   ifm4;
   logic [2:0][2:0][15:0]   ifm5;
   logic [3:0][3:0][15:0]   ofm4;
   logic [4:0][4:0][15:0]   ofm5;
   logic                    done4, done5;

   int checks   = 0;
   int failures = 0;
   int px [3][3];

   upsample #(.DATA_WIDTH(16), .CONV_OFMAP_SIZE(4), .POOL_OFMAP_SIZE(2)) dut4 (
      .clk(clk), .reset(reset), .en(en4), .up_ifmap(ifm4), .up_ofmap(ofm4), .up_done(done4));

   upsample #(.DATA_WIDTH(16), .CONV_OFMAP_SIZE(5), .POOL_OFMAP_SIZE(3)) dut5 (
      .clk(clk), .reset(reset), .en(en5), .up_ifmap(ifm5), .up_ofmap(ofm5), .up_done(done5));

   function automatic int pool_size(input int sel);
      return (sel == 4) ? 2 : 3;
   endfunction

   function automatic logic [15:0] dut_out(input int sel, input int r, input int c);
      if (sel == 4) return ofm4[r][c];
      return ofm5[r][c];
   endfunction

   function automatic logic dut_done(input int sel);
      return (sel == 4) ? done4 : done5;
   endfunction

   // Nearest-neighbour: output (r,c) comes from input (r/2,c/2); unpool keeps only even/even.
   function automatic logic [15:0] model_px(input int r, input int c);
      int v;
      v = px[r / 2][c / 2];
`ifdef UPSAMPLE_ZERO_FILL_EN
      if ((r % 2) != 0 || (c % 2) != 0) v = 0;
`endif
      return 16'(v);
   endfunction

   task automatic set_en(input int sel, input logic v);
      if (sel == 4) en4 = v;
      else          en5 = v;
   endtask

   task automatic load_ifmap(input int sel);
      for (int r = 0; r < pool_size(sel); r++)
         for (int c = 0; c < pool_size(sel); c++) begin
            if (sel == 4) ifm4[r][c] = 16'(px[r][c]);
            else          ifm5[r][c] = 16'(px[r][c]);
         end
   endtask

   task automatic random_px();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            px[r][c] = int'($urandom_range(1, 65535));
   endtask

   task automatic check_map(input int sel, input string name);
      logic [15:0] got, exp;
      for (int r = 0; r < sel; r++)
         for (int c = 0; c < sel; c++) begin
            got = dut_out(sel, r, c);
            exp = model_px(r, c);
            checks++;
            if (got !== exp) begin
               failures++;
               $display("FAIL %s map%0d[%0d][%0d] got=%0h exp=%0h", name, sel, r, c, got, exp);
            end
         end
   endtask

   task automatic check_zero(input int sel, input string name);
      logic [15:0] got;
      for (int r = 0; r < sel; r++)
         for (int c = 0; c < sel; c++) begin
            got = dut_out(sel, r, c);
            checks++;
            if (got !== 16'h0) begin
               failures++;
               $display("FAIL %s map%0d[%0d][%0d] got=%0h exp=0", name, sel, r, c, got);
            end
         end
   endtask

   task automatic check_done(input int sel, input logic exp, input string name);
      checks++;
      if (dut_done(sel) !== exp) begin
         failures++;
         $display("FAIL %s done%0d got=%b exp=%b", name, sel, dut_done(sel), exp);
      end
   endtask

   // Raises en, then counts edges after the sampling edge until up_done is seen.
   task automatic start_and_wait(input int sel, input string name);
      int lat;
      int exp_lat;
      lat     = 0;
      exp_lat = pool_size(sel) * pool_size(sel) + 2;
      set_en(sel, 1'b1);
      @(posedge clk);
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(posedge clk);
         #1;
         if (dut_done(sel) === 1'b1) lat = k;
      end
      checks++;
      if (lat != exp_lat) begin
         failures++;
         $display("FAIL %s latency%0d got=%0d exp=%0d (0 means timeout)", name, sel, lat, exp_lat);
      end
   endtask

   task automatic finish_run(input int sel, input string name);
      set_en(sel, 1'b0);
      @(posedge clk);
      #1;
      check_done(sel, 1'b0, name);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en4   = 1'b1;
      en5   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_done(4, 1'b0, "reset_hold");
      check_done(5, 1'b0, "reset_hold");
      check_zero(4, "reset_hold");
      check_zero(5, "reset_hold");
      en4   = 1'b0;
      en5   = 1'b0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_done(4, 1'b0, "reset_idle");
      check_done(5, 1'b0, "reset_idle");
      check_zero(5, "reset_idle");
   endtask

   task automatic test_directed();
      for (int i = 0; i < 9; i++) px[i / 3][i % 3] = i + 1;
`ifdef UPSAMPLE_ZERO_FILL_EN
      px[0][0] = 5; px[0][1] = 6; px[1][0] = 7; px[1][1] = 8;
`else
      px[0][0] = 1; px[0][1] = 2; px[1][0] = 3; px[1][1] = 4;
`endif
      load_ifmap(4);
      start_and_wait(4, "directed4");
      check_map(4, "directed4");
      finish_run(4, "directed4");
      for (int i = 0; i < 9; i++) px[i / 3][i % 3] = i + 1;
      load_ifmap(5);
      start_and_wait(5, "directed5");
      check_map(5, "directed5");
      finish_run(5, "directed5");
   endtask

   task automatic test_random();
      for (int n = 0; n < 3; n++) begin
         for (int s = 4; s <= 5; s++) begin
            random_px();
            load_ifmap(s);
            start_and_wait(s, "random");
            check_map(s, "random");
            finish_run(s, "random");
         end
      end
   endtask

   task automatic test_abort();
      random_px();
      load_ifmap(5);
      set_en(5, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      set_en(5, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_done(5, 1'b0, "abort_idle");
      random_px();
      load_ifmap(5);
      start_and_wait(5, "abort_restart");
      check_map(5, "abort_restart");
      finish_run(5, "abort_restart");
   endtask

   task automatic test_done_hold();
      random_px();
      load_ifmap(4);
      start_and_wait(4, "done_hold");
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check_done(4, 1'b1, "done_hold");
      end
      check_map(4, "done_hold");
      finish_run(4, "done_fall");
      check_map(4, "done_fall");
   endtask

   task automatic test_reset_midrun();
      random_px();
      load_ifmap(5);
      set_en(5, 1'b1);
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check_done(5, 1'b0, "reset_midrun");
      check_zero(5, "reset_midrun");
      set_en(5, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_done(5, 1'b0, "reset_release");
      random_px();
      load_ifmap(5);
      start_and_wait(5, "after_reset");
      check_map(5, "after_reset");
      finish_run(5, "after_reset");
   endtask

   initial begin
      reset = 1'b1;
      en4   = 1'b0;
      en5   = 1'b0;
      ifm4  = '0;
      ifm5  = '0;
      test_reset();
      test_directed();
      test_random();
      test_abort();
      test_done_hold();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/upsample.md
# upsample

Nearest-neighbour 2x upsampler for the CNN datapath. It expands a pooled feature map (POOL_OFMAP_SIZE square) back to convolution-output resolution (CONV_OFMAP_SIZE square) by writing each input pixel into its 2x2 output window. It is the inverse-direction counterpart of the max-pool stage and feeds decoder or skip-connection paths. It uses the same en/done start-and-finish handshake as the other layer blocks.

## Interface
- DATA_WIDTH, default from cnn_defs, pixel width.
- CONV_OFMAP_SIZE, default from cnn_defs, output map side length.
- POOL_OFMAP_SIZE, default (CONV_OFMAP_SIZE+1)/2, input map side length.
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  start/hold; level-sensitive.
- up_ifmap  input  DATA_WIDTH x [POOL_OFMAP_SIZE][POOL_OFMAP_SIZE]  pooled map, stable while en is high.
- up_ofmap  output  DATA_WIDTH x [CONV_OFMAP_SIZE][CONV_OFMAP_SIZE]  upsampled map, registered.
- up_done  output  1  map complete, registered.

## Operation
- Define N = POOL_OFMAP_SIZE².
- States:
  - UP_IDLE: counters cleared, up_done=0. Goes to UP_PROCESSING when en=1.
  - UP_PROCESSING: goes to UP_DRAIN when count==N. Otherwise goes to UP_IDLE when en=0.
  - UP_DRAIN: one cycle, then UP_DONE unconditionally.
  - UP_DONE: up_done=1. Goes to UP_IDLE when en=0.
- Address generation: row/col counters scan up_ifmap row-major.
  - col wraps at POOL_OFMAP_SIZE-1 and increments row.
  - count increments each PROCESSING cycle while count<N.
- Stage 1: register up_ifmap[row][col], row, col, and a valid bit.
- Stage 2: when valid, write the registered value to output positions (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
  - Any position with index ≥ CONV_OFMAP_SIZE is not written (odd-size clipping, no out-of-range access).
- Leaving PROCESSING for IDLE because en=0 aborts the run:
  - up_ofmap keeps its partial writes.
  - The pipeline valid bit is cleared.
  - The next en restarts from (0,0).
- up_ofmap holds its value in IDLE and DONE.
- Width rules:
  - Counters are $clog2(POOL_OFMAP_SIZE) bits.
  - count is $clog2(N)+1 bits.
  - Output index arithmetic is done in 32-bit before bounds comparison.

## Timing
- Reset values: state UP_IDLE, up_done=0, every up_ofmap element 0, counters and pipeline registers 0.
- Cycle sequence, with edge 0 the edge that samples en=1 in UP_IDLE:
  - Edges 1..N: stage-1 captures.
  - Edge N+1: last output write; state becomes UP_DRAIN.
  - Edge N+2: state becomes UP_DONE; up_done rises.
- Total latency: up_done is high N+2 cycles after start. All up_ofmap writes are complete before up_done is observed.
- up_done falls on the edge that samples en=0 in UP_DONE.
- en held high in UP_DONE keeps the block there; no auto-restart.
- Reset asserted mid-run clears everything immediately; there is no partial completion.

## Configuration
- Macro: UPSAMPLE_ZERO_FILL_EN.
- Defined: max-unpool style.
  - Only (2r,2c) receives the pixel.
  - (2r,2c+1), (2r+1,2c), (2r+1,2c+1) are written 0 in the same cycle, subject to the same clipping.
- Undefined: all four positions receive the pixel (nearest-neighbour replicate).
- Latency and handshake are identical in both builds.

## Structure
- Add up_state_t (UP_IDLE, UP_PROCESSING, UP_DRAIN, UP_DONE) to cnn_defs.svh alongside pool_state_t.
- Reuse DATA_WIDTH, CONV_OFMAP_SIZE, POOL_OFMAP_SIZE, POOL_PIXEL_COUNT from cnn_defs.
- One natural sub-module: upsample_addr_gen (row/col/count scan with wrap and terminal flag).
- The datapath stays in the top module.

## Test plan
- Reset check: assert reset with en=1 -> up_done=0, all up_ofmap=0, state idle after release until en is sampled.
- CONV=4, POOL=2, ifmap {{1,2},{3,4}}, replicate build -> ofmap rows {1,1,2,2},{1,1,2,2},{3,3,4,4},{3,3,4,4}; up_done high exactly 6 cycles after start.
- CONV=5, POOL=3, ifmap values 1..9 -> row 4 equals {7,7,8,8,9}; column 4 equals {3,3,6,6,9}; no X values; up_done after 11 cycles.
- UPSAMPLE_ZERO_FILL_EN build, CONV=4, ifmap {{5,6},{7,8}} -> ofmap rows {5,0,6,0},{0,0,0,0},{7,0,8,0},{0,0,0,0}.
- Abort: drop en after 2 PROCESSING cycles, then reassert -> run restarts at (0,0); up_done only after a full N+2 cycles.
- Done hold: keep en high for 10 cycles after done -> up_done stays 1 with ofmap stable; en low -> up_done 0 on the next edge.
